// File: rtl/accessor_if.sv
// rtl/accessor_if.sv - bundle of executor, writer and data-memory signals around the accessor
interface accessor_if;
    logic executor_valid;
    logic accessor_ready;
    logic accessor_valid;
    logic writer_ready;

    struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        is_lb;
        logic        is_lbu;
        logic        is_lh;
        logic        is_lhu;
        logic        is_lw;
        logic        is_sb;
        logic        is_sh;
        logic        is_sw;
    } in;

    struct packed {
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        trap;
    } out;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output executor_valid, writer_ready, in, mem_ready, mem_rdata,
        input  accessor_ready, accessor_valid, out, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  executor_valid, writer_ready, in, mem_ready, mem_rdata,
        output accessor_ready, accessor_valid, out, mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/accessor.sv
// rtl/accessor.sv - load/store stage: aligns, issues one data-memory access, holds result for the writer
module accessor (
    input  logic      clk,
    input  logic      reset,
    accessor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    state_t      state_q, state_d;
    logic [4:0]  out_rd_q, out_rd_d;
    logic [31:0] out_rd_data_q, out_rd_data_d;
    logic        out_trap_q, out_trap_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [1:0]  ld_size_q, ld_size_d;
    logic        ld_signed_q, ld_signed_d;

    logic        is_load, is_store, is_half, is_word, misaligned;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ld_result;

    assign is_load    = bus.in.is_lb | bus.in.is_lbu | bus.in.is_lh | bus.in.is_lhu | bus.in.is_lw;
    assign is_store   = bus.in.is_sb | bus.in.is_sh | bus.in.is_sw;
    assign is_half    = bus.in.is_lh | bus.in.is_lhu | bus.in.is_sh;
    assign is_word    = bus.in.is_lw | bus.in.is_sw;
    assign misaligned = (is_half & bus.in.mem_addr[0]) | (is_word & (|bus.in.mem_addr[1:0]));

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        if (bus.in.is_sb) begin
            st_wdata = {4{bus.in.mem_data[7:0]}};
            st_wstrb = 4'b0001 << bus.in.mem_addr[1:0];
        end else if (bus.in.is_sh) begin
            st_wdata = {2{bus.in.mem_data[15:0]}};
            st_wstrb = bus.in.mem_addr[1] ? 4'b1100 : 4'b0011;
        end else if (bus.in.is_sw) begin
            st_wdata = bus.in.mem_data;
            st_wstrb = 4'b1111;
        end
    end

    // ld_size: 0 = byte, 1 = halfword, 2 = word
    assign lane_byte = 8'(bus.mem_rdata >> {ld_off_q, 3'b000});
    assign lane_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        case (ld_size_q)
            2'd0:    ld_result = {{24{ld_signed_q & lane_byte[7]}}, lane_byte};
            2'd1:    ld_result = {{16{ld_signed_q & lane_half[15]}}, lane_half};
            default: ld_result = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        out_rd_d      = out_rd_q;
        out_rd_data_d = out_rd_data_q;
        out_trap_d    = out_trap_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wstrb_d   = mem_wstrb_q;
        ld_rd_d       = ld_rd_q;
        ld_off_d      = ld_off_q;
        ld_size_d     = ld_size_q;
        ld_signed_d   = ld_signed_q;
        case (state_q)
            IDLE: begin
                if (bus.executor_valid) begin
                    if (!(is_load | is_store)) begin
                        out_rd_d      = bus.in.rd;
                        out_rd_data_d = bus.in.rd_data;
                        out_trap_d    = 1'b0;
                        state_d       = HOLD;
                    end else if (misaligned) begin
                        out_rd_d      = '0;
                        out_rd_data_d = '0;
                        out_trap_d    = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {bus.in.mem_addr[31:2], 2'b00};
                        mem_wdata_d = st_wdata;
                        mem_wstrb_d = st_wstrb;
                        ld_rd_d     = bus.in.rd;
                        ld_off_d    = bus.in.mem_addr[1:0];
                        ld_size_d   = bus.in.is_lw ? 2'd2 :
                                      (bus.in.is_lh | bus.in.is_lhu) ? 2'd1 : 2'd0;
                        ld_signed_d = bus.in.is_lb | bus.in.is_lh;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    // A non-zero strobe marks a store, which never writes back a register
                    mem_valid_d   = 1'b0;
                    out_trap_d    = 1'b0;
                    out_rd_d      = (mem_wstrb_q == 4'b0000) ? ld_rd_q : 5'd0;
                    out_rd_data_d = (mem_wstrb_q == 4'b0000) ? ld_result : 32'd0;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.writer_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            out_rd_q      <= '0;
            out_rd_data_q <= '0;
            out_trap_q    <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wstrb_q   <= '0;
            ld_rd_q       <= '0;
            ld_off_q      <= '0;
            ld_size_q     <= '0;
            ld_signed_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_rd_q      <= out_rd_d;
            out_rd_data_q <= out_rd_data_d;
            out_trap_q    <= out_trap_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wstrb_q   <= mem_wstrb_d;
            ld_rd_q       <= ld_rd_d;
            ld_off_q      <= ld_off_d;
            ld_size_q     <= ld_size_d;
            ld_signed_q   <= ld_signed_d;
        end
    end

    assign bus.accessor_ready = (state_q == IDLE);
    assign bus.accessor_valid = (state_q == HOLD);
    assign bus.out            = {out_rd_q, out_rd_data_q, out_trap_q};
    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_wdata      = mem_wdata_q;
    assign bus.mem_wstrb      = mem_wstrb_q;
endmodule

// File: tb/tb_accessor.sv
// tb/tb_accessor.sv - directed cases then randomized traffic against a byte-addressed reference memory
module tb_accessor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    accessor_if bus();
    accessor dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        trap;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  ref_bytes [64];
    logic [31:0] mem_word [16];
    logic        rand_done;

    function automatic logic [7:0] pat(int i);
        return 8'(i * 29 + 7);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // op: 0 alu, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 sb, 7 sh, 8 sw
    task automatic drive_in(input int op, input logic [4:0] rd, input logic [31:0] rdd,
                            input logic [31:0] addr, input logic [31:0] data);
        bus.in.rd       = rd;
        bus.in.rd_data  = rdd;
        bus.in.mem_addr = addr;
        bus.in.mem_data = data;
        bus.in.is_lb    = (op == 1);
        bus.in.is_lbu   = (op == 2);
        bus.in.is_lh    = (op == 3);
        bus.in.is_lhu   = (op == 4);
        bus.in.is_lw    = (op == 5);
        bus.in.is_sb    = (op == 6);
        bus.in.is_sh    = (op == 7);
        bus.in.is_sw    = (op == 8);
    endtask

    task automatic handshake_out();
        bus.writer_ready = 1'b1;
        tick();
        check("ready_after_handshake", {31'd0, bus.accessor_ready}, 32'd1);
        bus.writer_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b0;
        bus.executor_valid = 1'b0;
        bus.writer_ready = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        rand_done = 1'b0;
        drive_in(0, 5'd0, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 64; i++) ref_bytes[i] = pat(i);
        for (int w = 0; w < 16; w++)
            mem_word[w] = {pat(4*w+3), pat(4*w+2), pat(4*w+1), pat(4*w)};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, bus.accessor_ready}, 32'd1);
        check("reset_avalid", {31'd0, bus.accessor_valid}, 32'd0);
        check("reset_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        check("reset_out_data", bus.out.rd_data, 32'd0);
        check("reset_mem_addr", bus.mem_addr, 32'd0);

        // ALU pass-through on the first edge after reset release
        @(negedge clk);
        reset = 1'b1;
        drive_in(0, 5'd5, 32'h1234, 32'h0, 32'h0);
        bus.executor_valid = 1'b1;
        bus.writer_ready = 1'b1;
        tick();
        bus.executor_valid = 1'b0;
        check("alu_avalid", {31'd0, bus.accessor_valid}, 32'd1);
        check("alu_ready_low", {31'd0, bus.accessor_ready}, 32'd0);
        check("alu_rd", {27'd0, bus.out.rd}, 32'd5);
        check("alu_data", bus.out.rd_data, 32'h1234);
        check("alu_trap", {31'd0, bus.out.trap}, 32'd0);
        tick();
        check("alu_ready_again", {31'd0, bus.accessor_ready}, 32'd1);
        check("alu_avalid_drop", {31'd0, bus.accessor_valid}, 32'd0);
        bus.writer_ready = 1'b0;

        // lb with three-cycle memory latency
        drive_in(1, 5'd7, 32'h0, 32'h103, 32'h0);
        bus.executor_valid = 1'b1;
        tick();
        bus.executor_valid = 1'b0;
        check("lb_addr", bus.mem_addr, 32'h100);
        check("lb_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.mem_valid) cnt++;
            if (k == 2) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h80FF_FF00;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        check("lb_mvalid_cycles", cnt, 32'd3);
        check("lb_mvalid_drop", {31'd0, bus.mem_valid}, 32'd0);
        check("lb_avalid", {31'd0, bus.accessor_valid}, 32'd1);
        check("lb_data", bus.out.rd_data, 32'hFFFF_FF80);
        check("lb_rd", {27'd0, bus.out.rd}, 32'd7);
        handshake_out();

        // sh with immediate memory completion
        drive_in(7, 5'd9, 32'h0, 32'h22, 32'hAAAA_BEEF);
        bus.executor_valid = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        bus.executor_valid = 1'b0;
        check("sh_mvalid", {31'd0, bus.mem_valid}, 32'd1);
        check("sh_addr", bus.mem_addr, 32'h20);
        check("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", {28'd0, bus.mem_wstrb}, 32'hC);
        tick();
        bus.mem_ready = 1'b0;
        check("sh_avalid", {31'd0, bus.accessor_valid}, 32'd1);
        check("sh_rd", {27'd0, bus.out.rd}, 32'd0);
        handshake_out();

        // misaligned lw traps without touching memory
        drive_in(5, 5'd3, 32'h0, 32'h41, 32'h0);
        bus.executor_valid = 1'b1;
        tick();
        bus.executor_valid = 1'b0;
        check("lw_mis_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        check("lw_mis_avalid", {31'd0, bus.accessor_valid}, 32'd1);
        check("lw_mis_trap", {31'd0, bus.out.trap}, 32'd1);
        check("lw_mis_rd", {27'd0, bus.out.rd}, 32'd0);
        check("lw_mis_data", bus.out.rd_data, 32'd0);
        handshake_out();

        // lhu held while the writer stalls
        drive_in(4, 5'd12, 32'h0, 32'h2, 32'h0);
        bus.executor_valid = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h9876_0000;
        tick();
        bus.executor_valid = 1'b0;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h1111_2222;
        for (int k = 0; k < 4; k++) begin
            check("lhu_hold_data", bus.out.rd_data, 32'h0000_9876);
            check("lhu_hold_ready", {31'd0, bus.accessor_ready}, 32'd0);
            tick();
        end
        handshake_out();

        // reset in the middle of an access abandons the request
        drive_in(5, 5'd4, 32'h0, 32'h10, 32'h0);
        bus.executor_valid = 1'b1;
        tick();
        bus.executor_valid = 1'b0;
        check("rst_pre_mvalid", {31'd0, bus.mem_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mvalid", {31'd0, bus.mem_valid}, 32'd0);
        check("rst_avalid", {31'd0, bus.accessor_valid}, 32'd0);
        check("rst_ready", {31'd0, bus.accessor_ready}, 32'd1);
        check("rst_addr", bus.mem_addr, 32'd0);
        #1;
        reset = 1'b1;
        tick();
        check("rst_release_ready", {31'd0, bus.accessor_ready}, 32'd1);
        check("rst_release_mvalid", {31'd0, bus.mem_valid}, 32'd0);

        fork
            begin : driver
                int          op, a, k, hv;
                logic [4:0]  rd;
                logic [31:0] tmp, addr, data, rdd, val;
                logic        accepted, r, mis, is_mem;
                exp_t        e;
                req_t        q;
                for (int n = 0; n < 300; n++) begin
                    op   = $urandom_range(0, 8);
                    rd   = 5'($urandom_range(0, 31));
                    a    = $urandom_range(0, 63);
                    tmp  = $urandom();
                    addr = {tmp[31:6], 6'(a)};
                    data = $urandom();
                    rdd  = $urandom();
                    drive_in(op, rd, rdd, addr, data);
                    bus.executor_valid = 1'b1;
                    accepted = 1'b0;
                    for (k = 0; k < 200 && !accepted; k++) begin
                        @(negedge clk);
                        r = bus.accessor_ready;
                        @(posedge clk);
                        if (r) accepted = 1'b1;
                    end
                    #1;
                    if (!accepted) begin
                        check("transfer_timeout", 32'd0, 32'd1);
                        break;
                    end
                    is_mem = (op != 0);
                    mis = ((op == 3 || op == 4 || op == 7) && (a % 2 != 0)) ||
                          ((op == 5 || op == 8) && (a % 4 != 0));
                    e.trap = 1'b0; e.chk_data = 1'b1; e.rd = rd; e.data = rdd;
                    if (is_mem && mis) begin
                        e.rd = 0; e.data = 0; e.trap = 1'b1;
                    end else if (is_mem) begin
                        q.addr = addr & ~32'd3;
                        q.wdata = 0;
                        q.wstrb = 0;
                        if (op >= 6) begin
                            e.rd = 0; e.chk_data = 1'b0;
                            if (op == 6) begin
                                q.wdata = {4{data[7:0]}}; q.wstrb = 4'(1 << (a % 4));
                                ref_bytes[a] = data[7:0];
                            end else if (op == 7) begin
                                q.wdata = {2{data[15:0]}}; q.wstrb = (a % 4 == 2) ? 4'hC : 4'h3;
                                ref_bytes[a] = data[7:0]; ref_bytes[a+1] = data[15:8];
                            end else begin
                                q.wdata = data; q.wstrb = 4'hF;
                                for (int b = 0; b < 4; b++) ref_bytes[a+b] = data[8*b +: 8];
                            end
                        end else begin
                            if (op <= 2) begin
                                hv = ref_bytes[a];
                                if (op == 1 && hv >= 128) hv = hv - 256;
                            end else if (op <= 4) begin
                                hv = ref_bytes[a] + 256 * ref_bytes[a+1];
                                if (op == 3 && hv >= 32768) hv = hv - 65536;
                            end else begin
                                hv = 0;
                            end
                            val = 32'(hv);
                            if (op == 5) val = {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
                            e.data = val;
                        end
                        req_q.push_back(q);
                    end
                    exp_q.push_back(e);
                    // a request offered while busy must be ignored
                    if ($urandom_range(0, 1) == 1) begin
                        drive_in($urandom_range(0, 8), 5'($urandom_range(0, 31)), $urandom(), $urandom(), $urandom());
                        tick();
                    end
                    bus.executor_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
                bus.executor_valid = 1'b0;
                for (k = 0; k < 1000 && (exp_q.size() != 0 || req_q.size() != 0); k++) @(posedge clk);
                check("drain_exp_q", exp_q.size(), 32'd0);
                check("drain_req_q", req_q.size(), 32'd0);
                rand_done = 1'b1;
            end
            begin : responder
                int   wait_cnt;
                req_t q;
                wait_cnt = $urandom_range(0, 3);
                forever begin
                    @(negedge clk);
                    if (bus.mem_ready) begin
                        bus.mem_ready = 1'b0;
                    end else if (bus.mem_valid) begin
                        if (wait_cnt > 0) begin
                            wait_cnt--;
                            bus.mem_rdata = $urandom();
                        end else begin
                            if (req_q.size() == 0) begin
                                check("unexpected_mem_req", 32'd1, 32'd0);
                            end else begin
                                q = req_q.pop_front();
                                check("req_addr", bus.mem_addr, q.addr);
                                check("req_wstrb", {28'd0, bus.mem_wstrb}, {28'd0, q.wstrb});
                                if (q.wstrb != 0) check("req_wdata", bus.mem_wdata, q.wdata);
                            end
                            bus.mem_rdata = mem_word[bus.mem_addr[5:2]];
                            for (int b = 0; b < 4; b++)
                                if (bus.mem_wstrb[b]) mem_word[bus.mem_addr[5:2]][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                            bus.mem_ready = 1'b1;
                            wait_cnt = $urandom_range(0, 3);
                        end
                    end
                end
            end
            begin : writer
                forever begin
                    tick();
                    bus.writer_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin : monitor
                exp_t        e;
                logic [37:0] prev;
                logic        held;
                held = 1'b0;
                prev = '0;
                forever begin
                    @(negedge clk);
                    if (bus.mem_valid && bus.accessor_valid) check("mvalid_avalid_overlap", 32'd1, 32'd0);
                    if (held && bus.accessor_valid) check("out_stable", {26'd0, bus.out[37:32]} ^ {26'd0, prev[37:32]} | (bus.out[31:0] ^ prev[31:0]), 32'd0);
                    held = bus.accessor_valid && !bus.writer_ready;
                    prev = bus.out;
                    if (bus.accessor_valid && bus.writer_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check("out_rd", {27'd0, bus.out.rd}, {27'd0, e.rd});
                            check("out_trap", {31'd0, bus.out.trap}, {31'd0, e.trap});
                            if (e.chk_data) check("out_rd_data", bus.out.rd_data, e.data);
                        end
                    end
                end
            end
        join_any
        disable fork;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
